// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
//   Dual-issue, in-order issue stage between decode and the execute pipes.
//   Holds one decoded instruction pair, reads the scoreboard for all four
//   sources, issues 0/1/2 instructions per cycle in program order and writes
//   the scoreboard entry of every issued register-writing instruction.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   stall             backend stall: freezes buffer, suppresses issue/writes
//   flash             pipeline flush: empties the buffer on the next edge
//   in_valid/ready    decode handshake for one instruction pair
//   in_slot_valid     per-slot valid (slot0 older, 2'b10 illegal)
//   in_src/dst/dst_we/lat  decoded pair fields (lat = latency - 1)
//   sb_read_addr      four scoreboard read addresses, index 2*slot+src
//   sb_data_out       scoreboard read results (position vectors)
//   sb_write_*        scoreboard write port per slot
//   issue_valid       per-slot issue strobe
//   issue_fwd         per-source operand select (1 = forward bus)
// ---------------------------------------------------------------------------
module issue_scheduler #(
  parameter int POS_W = 4,
  parameter int LAT_W = 2,
  parameter int REG_W = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             flash,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_slot_valid,
  input  logic [1:0][1:0][REG_W-1:0]       in_src,
  input  logic [1:0][REG_W-1:0]            in_dst,
  input  logic [1:0]                       in_dst_we,
  input  logic [1:0][LAT_W-1:0]            in_lat,
  output logic [3:0][REG_W-1:0]            sb_read_addr,
  input  logic [3:0][POS_W-1:0]            sb_data_out,
  output logic [1:0]                       sb_write_ena,
  output logic [1:0][REG_W-1:0]            sb_write_addr,
  output logic [1:0][POS_W-1:0]            sb_data_in,
  output logic [1:0]                       issue_valid,
  output logic [1:0][1:0]                  issue_fwd
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_PAIR   = 2'd1,
    S_SINGLE = 2'd2
  } state_t;

  state_t                       r_state;
  logic [1:0][1:0][REG_W-1:0]   r_src;
  logic [1:0][REG_W-1:0]        r_dst;
  logic [1:0]                   r_dst_we;
  logic [1:0][LAT_W-1:0]        r_lat;

  logic [3:0]                   w_rdy;
  logic [3:0]                   w_fwd;
  logic                         w_hazard;
  logic                         w_head_go;
  logic                         w_sec_go;
  logic                         w_next_empty;
  logic [POS_W-1:0]             w_pos_one;

  assign w_pos_one = {{(POS_W-1){1'b0}}, 1'b1};

  // Scoreboard read addresses: unoccupied slots read register 0 so they
  // always look ready and never request forwarding.
  always_comb begin
    sb_read_addr = '0;
    if (r_state == S_PAIR) begin
      sb_read_addr[0] = r_src[0][0];
      sb_read_addr[1] = r_src[0][1];
      sb_read_addr[2] = r_src[1][0];
      sb_read_addr[3] = r_src[1][1];
    end else if (r_state == S_SINGLE) begin
      sb_read_addr[0] = r_src[0][0];
      sb_read_addr[1] = r_src[0][1];
    end else begin
      sb_read_addr = '0;
    end
  end

  // Per-source readiness: only a result still more than one shift away blocks.
  always_comb begin
    w_rdy = '0;
    w_fwd = '0;
    for (int i = 0; i < 4; i++) begin
      w_rdy[i] = (sb_read_addr[i] == '0) || (sb_data_out[i][POS_W-1:1] == '0);
      w_fwd[i] = (sb_read_addr[i] != '0) && sb_data_out[i][0];
    end
  end

  assign issue_fwd[0] = w_fwd[1:0];
  assign issue_fwd[1] = w_fwd[3:2];

  // The second instruction cannot see the head's result in the same cycle.
  assign w_hazard = r_dst_we[0] && (r_dst[0] != '0) &&
                    ((r_src[1][0] == r_dst[0]) || (r_src[1][1] == r_dst[0]));

  assign w_head_go = (r_state != S_EMPTY) && w_rdy[0] && w_rdy[1] && !stall && !flash;
  assign w_sec_go  = w_head_go && (r_state == S_PAIR) && w_rdy[2] && w_rdy[3] && !w_hazard;

  assign issue_valid = {w_sec_go, w_head_go};

  // Scoreboard write port: one-hot position at the producer's latency.
  always_comb begin
    sb_write_ena  = '0;
    sb_write_addr = '0;
    sb_data_in    = '0;
    for (int k = 0; k < 2; k++) begin
      if (issue_valid[k] && r_dst_we[k] && (r_dst[k] != '0)) begin
        sb_write_ena[k]  = 1'b1;
        sb_write_addr[k] = r_dst[k];
        sb_data_in[k]    = w_pos_one << r_lat[k];
      end else begin
        sb_write_ena[k]  = 1'b0;
      end
    end
  end

  // Buffer drains completely this cycle -> a new pair may enter bubble-free.
  always_comb begin
    case (r_state)
      S_EMPTY:  w_next_empty = 1'b1;
      S_PAIR:   w_next_empty = w_sec_go;
      S_SINGLE: w_next_empty = w_head_go;
      default:  w_next_empty = 1'b1;
    endcase
  end

  assign in_ready = w_next_empty && !stall && !flash;

  // Buffer state machine and instruction storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_src    <= '0;
      r_dst    <= '0;
      r_dst_we <= '0;
      r_lat    <= '0;
    end else if (flash) begin
      r_state <= S_EMPTY;
    end else if (in_valid && in_ready) begin
      r_src    <= in_src;
      r_dst    <= in_dst;
      r_dst_we <= in_dst_we;
      r_lat    <= in_lat;
      case (in_slot_valid)
        2'b11:   r_state <= S_PAIR;
        2'b01:   r_state <= S_SINGLE;
        default: r_state <= S_EMPTY;
      endcase
    end else begin
      case (r_state)
        S_PAIR: begin
          if (w_sec_go) begin
            r_state <= S_EMPTY;
          end else if (w_head_go) begin
            // The younger instruction becomes the new head.
            r_state     <= S_SINGLE;
            r_src[0]    <= r_src[1];
            r_dst[0]    <= r_dst[1];
            r_dst_we[0] <= r_dst_we[1];
            r_lat[0]    <= r_lat[1];
          end else begin
            r_state <= S_PAIR;
          end
        end
        S_SINGLE: begin
          if (w_head_go) begin
            r_state <= S_EMPTY;
          end else begin
            r_state <= S_SINGLE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue in-order issue stage that sits between decode and the execute pipes and is the only writer/consumer of `score_board`. It holds one decoded instruction pair, drives the four scoreboard read addresses and checks the returned entries for RAW hazards, and issues 0, 1 or 2 instructions per cycle in program order. For every issued instruction that writes a register, it writes the destination's scoreboard entry with the producer's latency.

## Interface
Parameters:
- `POS_W`, 4: width of `SCORE_BOARD_DATA.position`; bit k set = result reaches the forward bus after k more shifts.
- `LAT_W`, 2: width of the per-instruction latency field; latency 1..POS_W.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset, asynchronous, active-high; clears all state.
- `stall`  in  1  backend stall. Freezes the buffer and suppresses issue and scoreboard writes; the same net drives `score_board.stall`.
- `flash`  in  1  pipeline flush; empties the buffer next edge. The same net drives `score_board.flash`.
- `in_valid`  in  1  decode offers a pair.
- `in_ready`  out  1  the pair is accepted this edge when in_valid && in_ready.
- `in_slot_valid`  in  [1:0]  per-slot valid (slot0 is older); 2'b10 is illegal.
- `in_src`  in  REG_ADDR [1:0][1:0]  source registers per slot.
- `in_dst`  in  REG_ADDR [1:0]  destination register per slot.
- `in_dst_we`  in  bool [1:0]  slot writes its destination.
- `in_lat`  in  [1:0][LAT_W-1:0]  result latency minus 1.
- `sb_read_addr`  out  REG_ADDR [3:0]  index 2*slot+src.
- `sb_data_out`  in  SCORE_BOARD_DATA [3:0]  scoreboard read result, combinational.
- `sb_write_ena`  out  bool [1:0]  per issued slot.
- `sb_write_addr`  out  REG_ADDR [1:0]  scoreboard write address per slot.
- `sb_data_in`  out  SCORE_BOARD_DATA [1:0]  scoreboard write data per slot.
- `issue_valid`  out  [1:0]  slot issues this cycle.
- `issue_fwd`  out  [1:0][1:0]  per source: 1 = take the forward bus, 0 = take the register file.

## Operation
- Buffer state machine: EMPTY, PAIR (two instructions, head = slot0), SINGLE (one instruction, held in the slot0 position).
- Sources for the four reads come from the buffer. In SINGLE, reads 2-3 are driven with 0.
- Source ready when: src == 0, or position[POS_W-1:1] == 0.
  - `issue_fwd` = position[0], forced 0 when src == 0.
- Head issues if both of its sources are ready and stall == 0.
- Second issues only if all of the following hold:
  - the head issues;
  - both of the second's sources are ready;
  - neither of the second's sources equals the head's dst while the head has dst_we && dst != 0.
- Nothing issues out of order; a blocked head blocks the second.
- For each issued slot with dst_we && dst != 0:
  - sb_write_ena = 1;
  - sb_write_addr = dst;
  - sb_data_in.position = 1 << lat;
  - all other SCORE_BOARD_DATA fields are 0.
- Both slots writing the same dst: both write enables are asserted; the scoreboard keeps slot1 by its own rule.
- Transitions (absent stall/flash):
  - PAIR, 2 issued → EMPTY.
  - PAIR, head only → SINGLE (the second moves into the head position).
  - SINGLE, issued → EMPTY.
  - Otherwise the state holds.
- `in_ready` = (next state would be EMPTY) && !stall && !flash.
  - An accepted pair loads into PAIR, or into SINGLE when in_slot_valid == 2'b01.
  - `in_valid` with in_slot_valid == 0 is accepted and discarded.
- `flash` takes priority over everything: no issue, no write, in_ready = 0, and the state is EMPTY after the edge.
- `rst` (asynchronous) forces EMPTY immediately.

## Timing
- Reset values:
  - state EMPTY;
  - in_ready = 1 (it is combinational, so it reads 1 once rst deasserts);
  - issue_valid = 0, sb_write_ena = 0, issue_fwd = 0;
  - sb_read_addr = 0, sb_write_addr = 0, sb_data_in = 0.
- issue_valid, issue_fwd, sb_write_* and in_ready are combinational from the buffer and sb_data_out in the same cycle.
- A pair accepted at edge N can issue in the cycle after edge N; the minimum issue latency is 1 cycle from acceptance.
- Throughput is 2 instructions per cycle with no hazards. A new pair is accepted in the same cycle the current pair fully issues (bubble-free).
- Scoreboard writes from cycle N become visible to reads after edge N. Same-cycle producer/consumer pairs inside the buffer are covered only by the intra-pair check.
- A write with latency L makes a consumer ready (forwarding) L-1 cycles after the write edge; after L edges position is 0 and the consumer uses the register file.
- stall freezes the state. Combinational outputs still reflect readiness, but issue_valid and sb_write_ena are forced to 0.

## Test plan
- Reset, then pair {add r3←r1,r2 lat0; add r4←r5,r6 lat0} with a clean scoreboard → next cycle issue_valid = 2'b11, sb_write_ena = 2'b11, addresses 3 and 4, position 4'b0001, issue_fwd all 0, in_ready = 1.
- Intra-pair RAW: {r3←r1,r2; r5←r3,r0} → cycle 1 issue_valid = 2'b01 and state SINGLE; cycle 2 slot0 issues with issue_fwd[0][0] = 1 (r3 position = 1). In cycle 2 in_ready = 1 and a new pair is accepted.
- Load-use: scoreboard r7 position = 4'b0100, head reads r7 → held 2 cycles (positions 0100, 0010). Issues in cycle 3 with fwd = 1; no sb writes while held.
- Same dst: {r9←…, lat1; r9←…, lat0}, no deps → sb_write_ena = 2'b11, both addresses 9; the scoreboard ends with r9 position 4'b0001.
- stall held 3 cycles with a ready pair → issue_valid = 0, sb_write_ena = 0, in_ready = 0 throughout. Both instructions issue in the first unstalled cycle.
- flash in SINGLE concurrent with in_valid → no issue, pair not accepted, EMPTY after the edge. Asserting rst mid-PAIR clears all outputs asynchronously.
